// File: rtl/axi_read_arbiter.sv
// Two-master read arbiter: serializes IFU fetches and MEM loads onto one AXI read
// channel as single-beat bursts; MEM has fixed priority over IFU.
module axi_read_arbiter #(
  parameter logic [3:0] IFU_ID = 4'h0,
  parameter logic [3:0] MEM_ID = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ARBITER_IFU_raddr_valid,
  input  logic [31:0] ARBITER_IFU_raddr,
  output logic        ARBITER_IFU_raddr_ready,
  output logic [63:0] ARBITER_IFU_rdata,
  output logic        ARBITER_IFU_rdata_valid,
  input  logic        ARBITER_IFU_rdata_ready,
  input  logic        ARBITER_MEM_raddr_valid,
  input  logic [31:0] ARBITER_MEM_raddr,
  input  logic [2:0]  ARBITER_MEM_rsize,
  output logic        ARBITER_MEM_raddr_ready,
  output logic [63:0] ARBITER_MEM_rdata,
  output logic        ARBITER_MEM_rdata_valid,
  input  logic        ARBITER_MEM_rdata_ready,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [63:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  output logic        ARBITER_error_signal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        gnt_mem_r;
  logic [31:0] addr_r;
  logic [2:0]  size_r;
  logic [3:0]  id_r;
  logic        error_r;

  logic        mem_hs_s;
  logic        ifu_hs_s;
  logic        ar_hs_s;
  logic        r_hs_s;
  logic        mem_ready_s;
  logic        ifu_ready_s;
  logic        arvalid_s;
  logic        rready_s;
  logic        mem_rvalid_s;
  logic        ifu_rvalid_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_hs_s || ifu_hs_s) begin
          state_nxt_s = ST_AR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_AR: begin
        if (ar_hs_s) begin
          state_nxt_s = ST_R;
        end else begin
          state_nxt_s = ST_AR;
        end
      end
      ST_R: begin
        if (r_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_R;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; address readies are held low while reset is asserted
  always_comb begin
    mem_ready_s  = 1'b0;
    ifu_ready_s  = 1'b0;
    arvalid_s    = 1'b0;
    rready_s     = 1'b0;
    mem_rvalid_s = 1'b0;
    ifu_rvalid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rst) begin
          mem_ready_s = 1'b0;
          ifu_ready_s = 1'b0;
        end else if (ARBITER_MEM_raddr_valid) begin
          mem_ready_s = 1'b1;
        end else begin
          ifu_ready_s = ARBITER_IFU_raddr_valid;
        end
      end
      ST_AR: begin
        arvalid_s = 1'b1;
      end
      ST_R: begin
        if (gnt_mem_r) begin
          rready_s     = ARBITER_MEM_rdata_ready;
          mem_rvalid_s = io_master_rvalid;
        end else begin
          rready_s     = ARBITER_IFU_rdata_ready;
          ifu_rvalid_s = io_master_rvalid;
        end
      end
      default: begin
        arvalid_s = 1'b0;
      end
    endcase
  end

  assign mem_hs_s = mem_ready_s & ARBITER_MEM_raddr_valid;
  assign ifu_hs_s = ifu_ready_s & ARBITER_IFU_raddr_valid;
  assign ar_hs_s  = arvalid_s & io_master_arready;
  assign r_hs_s   = rready_s & io_master_rvalid;

  // Request latch: owner, address, size and ID captured at grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_mem_r <= 1'b0;
      addr_r    <= 32'd0;
      size_r    <= 3'd0;
      id_r      <= 4'd0;
    end else if (mem_hs_s) begin
      gnt_mem_r <= 1'b1;
      addr_r    <= ARBITER_MEM_raddr;
      size_r    <= ARBITER_MEM_rsize;
      id_r      <= MEM_ID;
    end else if (ifu_hs_s) begin
      gnt_mem_r <= 1'b0;
      addr_r    <= ARBITER_IFU_raddr;
      size_r    <= 3'b010;
      id_r      <= IFU_ID;
    end else begin
      gnt_mem_r <= gnt_mem_r;
      addr_r    <= addr_r;
      size_r    <= size_r;
      id_r      <= id_r;
    end
  end

  // Response check, refreshed on every data handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_r <= 1'b0;
    end else if (r_hs_s) begin
      error_r <= (io_master_rresp != 2'b00) | (io_master_rid != id_r) | ~io_master_rlast;
    end else begin
      error_r <= error_r;
    end
  end

  assign ARBITER_MEM_raddr_ready = mem_ready_s;
  assign ARBITER_IFU_raddr_ready = ifu_ready_s;
  assign io_master_arvalid       = arvalid_s;
  assign io_master_araddr        = addr_r;
  assign io_master_arsize        = size_r;
  assign io_master_arid          = id_r;
  assign io_master_arlen         = 8'd0;
  assign io_master_arburst       = 2'b01;
  assign io_master_rready        = rready_s;
  assign ARBITER_MEM_rdata_valid = mem_rvalid_s;
  assign ARBITER_IFU_rdata_valid = ifu_rvalid_s;
  assign ARBITER_MEM_rdata       = io_master_rdata;
  assign ARBITER_IFU_rdata       = io_master_rdata;
  assign ARBITER_error_signal    = error_r;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter; inputs change at posedge+1,
// outputs are checked one time unit later, well before the next rising edge.
module tb_axi_read_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_valid;
  logic [31:0] ifu_addr;
  logic        ifu_ready;
  logic [63:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rready;
  logic        arready;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [63:0] rdata;
  logic        rlast;
  logic [3:0]  rid;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  axi_read_arbiter dut (
    .clk                     (clk),
    .rst                     (rst),
    .ARBITER_IFU_raddr_valid (ifu_valid),
    .ARBITER_IFU_raddr       (ifu_addr),
    .ARBITER_IFU_raddr_ready (ifu_ready),
    .ARBITER_IFU_rdata       (ifu_rdata),
    .ARBITER_IFU_rdata_valid (ifu_rvalid),
    .ARBITER_IFU_rdata_ready (ifu_rready),
    .ARBITER_MEM_raddr_valid (mem_valid),
    .ARBITER_MEM_raddr       (mem_addr),
    .ARBITER_MEM_rsize       (mem_size),
    .ARBITER_MEM_raddr_ready (mem_ready),
    .ARBITER_MEM_rdata       (mem_rdata),
    .ARBITER_MEM_rdata_valid (mem_rvalid),
    .ARBITER_MEM_rdata_ready (mem_rready),
    .io_master_arready       (arready),
    .io_master_arvalid       (arvalid),
    .io_master_araddr        (araddr),
    .io_master_arid          (arid),
    .io_master_arlen         (arlen),
    .io_master_arsize        (arsize),
    .io_master_arburst       (arburst),
    .io_master_rready        (rready),
    .io_master_rvalid        (rvalid),
    .io_master_rresp         (rresp),
    .io_master_rdata         (rdata),
    .io_master_rlast         (rlast),
    .io_master_rid           (rid),
    .ARBITER_error_signal    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ifu_valid = 1'b0; ifu_addr = 32'd0; ifu_rready = 1'b0;
    mem_valid = 1'b0; mem_addr = 32'd0; mem_size = 3'd0; mem_rready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 64'd0; rlast = 1'b0; rid = 4'd0;

    // reset state, with a pending request that must not be accepted
    #2;
    ifu_valid = 1'b1;
    #1;
    check_eq("rst_ifu_ready", {63'd0, ifu_ready}, 64'd0);
    check_eq("rst_arvalid", {63'd0, arvalid}, 64'd0);
    check_eq("rst_rready", {63'd0, rready}, 64'd0);
    check_eq("rst_err", {63'd0, err}, 64'd0);
    check_eq("rst_araddr", {32'd0, araddr}, 64'd0);
    ifu_valid = 1'b0;
    step();
    rst = 1'b1;
    step();

    // 1: IFU alone, bus ready immediately; rvalid outside R must be ignored
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0004; ifu_rready = 1'b1; arready = 1'b1;
    rvalid = 1'b1; rdata = 64'h1122_3344_5566_7788; rid = 4'd0; rlast = 1'b1; rresp = 2'b00;
    #1;
    check_eq("t1_ifu_ready", {63'd0, ifu_ready}, 64'd1);
    check_eq("t1_mem_ready", {63'd0, mem_ready}, 64'd0);
    check_eq("t1_idle_ifu_rvalid", {63'd0, ifu_rvalid}, 64'd0);
    step();
    ifu_valid = 1'b0;
    #1;
    check_eq("t1_arvalid", {63'd0, arvalid}, 64'd1);
    check_eq("t1_araddr", {32'd0, araddr}, 64'h8000_0004);
    check_eq("t1_arsize", {61'd0, arsize}, 64'd2);
    check_eq("t1_arid", {60'd0, arid}, 64'd0);
    check_eq("t1_arlen", {56'd0, arlen}, 64'd0);
    check_eq("t1_arburst", {62'd0, arburst}, 64'd1);
    step();
    check_eq("t1_rready", {63'd0, rready}, 64'd1);
    check_eq("t1_ifu_rvalid", {63'd0, ifu_rvalid}, 64'd1);
    check_eq("t1_ifu_rdata", ifu_rdata, 64'h1122_3344_5566_7788);
    check_eq("t1_mem_rvalid", {63'd0, mem_rvalid}, 64'd0);
    check_eq("t1_r_arvalid", {63'd0, arvalid}, 64'd0);
    step();
    rvalid = 1'b0;
    #1;
    check_eq("t1_idle_rready", {63'd0, rready}, 64'd0);
    check_eq("t1_err", {63'd0, err}, 64'd0);

    // 2: simultaneous requests, MEM wins
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0010;
    mem_valid = 1'b1; mem_addr = 32'h8000_1001; mem_size = 3'd0; mem_rready = 1'b1;
    #1;
    check_eq("t2_mem_ready", {63'd0, mem_ready}, 64'd1);
    check_eq("t2_ifu_ready", {63'd0, ifu_ready}, 64'd0);
    step();
    mem_valid = 1'b0;
    #1;
    check_eq("t2_m_arid", {60'd0, arid}, 64'd1);
    check_eq("t2_m_arsize", {61'd0, arsize}, 64'd0);
    check_eq("t2_m_araddr", {32'd0, araddr}, 64'h8000_1001);
    check_eq("t2_ar_ifu_ready", {63'd0, ifu_ready}, 64'd0);
    step();
    rvalid = 1'b1; rid = 4'd1; rdata = 64'hA5A5_0000_FFFF_1234;
    #1;
    check_eq("t2_mem_rvalid", {63'd0, mem_rvalid}, 64'd1);
    check_eq("t2_mem_rdata", mem_rdata, 64'hA5A5_0000_FFFF_1234);
    check_eq("t2_r_ifu_rvalid", {63'd0, ifu_rvalid}, 64'd0);
    check_eq("t2_r_ifu_ready", {63'd0, ifu_ready}, 64'd0);
    step();
    rvalid = 1'b0;
    #1;
    check_eq("t2_idle_ifu_ready", {63'd0, ifu_ready}, 64'd1);
    check_eq("t2_m_err", {63'd0, err}, 64'd0);
    step();
    ifu_valid = 1'b0;
    #1;
    check_eq("t2_i_arid", {60'd0, arid}, 64'd0);
    check_eq("t2_i_araddr", {32'd0, araddr}, 64'h8000_0010);
    check_eq("t2_i_arsize", {61'd0, arsize}, 64'd2);
    step();
    rvalid = 1'b1; rid = 4'd0; rdata = 64'h0BAD_CAFE_0000_0001;
    #1;
    check_eq("t2_ifu_rvalid", {63'd0, ifu_rvalid}, 64'd1);
    check_eq("t2_ifu_rdata", ifu_rdata, 64'h0BAD_CAFE_0000_0001);
    step();
    rvalid = 1'b0;

    // 3: AR stall for 5 cycles, MEM half-word load
    arready = 1'b0; mem_valid = 1'b1; mem_addr = 32'h8000_2002; mem_size = 3'd1;
    step();
    mem_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t3_arvalid", {63'd0, arvalid}, 64'd1);
      check_eq("t3_araddr", {32'd0, araddr}, 64'h8000_2002);
      check_eq("t3_arsize", {61'd0, arsize}, 64'd1);
      check_eq("t3_arid", {60'd0, arid}, 64'd1);
      step();
    end
    arready = 1'b1;
    #1;
    check_eq("t3_arvalid_hs", {63'd0, arvalid}, 64'd1);
    step();
    #1;
    check_eq("t3_no_second_ar", {63'd0, arvalid}, 64'd0);

    // 4: owner stalls data for 3 cycles
    mem_rready = 1'b0; rvalid = 1'b1; rid = 4'd1; rlast = 1'b1; rresp = 2'b00;
    rdata = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_stall_rready", {63'd0, rready}, 64'd0);
      check_eq("t4_stall_mem_rvalid", {63'd0, mem_rvalid}, 64'd1);
      step();
    end
    mem_rready = 1'b1;
    #1;
    check_eq("t4_rready", {63'd0, rready}, 64'd1);
    check_eq("t4_mem_rdata", mem_rdata, 64'hDEAD_BEEF_0123_4567);
    step();
    #1;
    check_eq("t4_after_rready", {63'd0, rready}, 64'd0);
    rvalid = 1'b0; ifu_valid = 1'b1;
    #1;
    check_eq("t4_back_idle", {63'd0, ifu_ready}, 64'd1);
    ifu_valid = 1'b0;
    step();

    // 5: SLVERR sets error, OKAY clears, then an ID mismatch sets it again
    mem_valid = 1'b1; mem_addr = 32'h8000_3000; mem_size = 3'd2;
    step();
    mem_valid = 1'b0;
    step();
    rvalid = 1'b1; rresp = 2'b10; rid = 4'd1; rlast = 1'b1;
    #1;
    check_eq("t5_err_before", {63'd0, err}, 64'd0);
    step();
    rvalid = 1'b0; rresp = 2'b00;
    #1;
    check_eq("t5_slverr", {63'd0, err}, 64'd1);
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    #1;
    check_eq("t5_err_hold", {63'd0, err}, 64'd1);
    step();
    rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    #1;
    check_eq("t5_okay_clear", {63'd0, err}, 64'd0);
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    step();
    rvalid = 1'b1; rid = 4'd0;
    step();
    rvalid = 1'b0;
    #1;
    check_eq("t5_rid_err", {63'd0, err}, 64'd1);

    // 6: async reset in AR, then normal IFU grant
    arready = 1'b0; ifu_valid = 1'b1; ifu_addr = 32'h8000_0020;
    step();
    ifu_valid = 1'b0;
    #1;
    check_eq("t6_in_ar", {63'd0, arvalid}, 64'd1);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_arvalid", {63'd0, arvalid}, 64'd0);
    check_eq("t6_rst_err", {63'd0, err}, 64'd0);
    step();
    rst = 1'b1;
    step();
    ifu_valid = 1'b1; arready = 1'b1;
    #1;
    check_eq("t6_ifu_ready", {63'd0, ifu_ready}, 64'd1);
    step();
    ifu_valid = 1'b0;
    #1;
    check_eq("t6_araddr", {32'd0, araddr}, 64'h8000_0020);
    check_eq("t6_arvalid", {63'd0, arvalid}, 64'd1);
    step();
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b1; rdata = 64'h7777_6666_5555_4444;
    #1;
    check_eq("t6_ifu_rvalid", {63'd0, ifu_rvalid}, 64'd1);
    step();
    rvalid = 1'b0;
    #1;
    check_eq("t6_err", {63'd0, err}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

- Arbitrates between the two CPU read masters, IFU (instruction fetch) and MEM (data load), onto the single AXI-full read channel of the SoC bus.
- Each master talks to the arbiter over the team's easy AXI-lite read handshake: address phase, then 64-bit data phase.
- The arbiter serializes requests, issues one single-beat AXI burst per request, and returns the raw 64-bit beat to the granted master.
- Alignment and extension stay in the masters.

## Interface
Parameters:
- `IFU_ID`, default 4'h0: `arid` used for IFU transactions.
- `MEM_ID`, default 4'h1: `arid` used for MEM transactions.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous and active-low (asserted when 0).
- `ARBITER_IFU_raddr_valid` in 1: IFU read request valid.
- `ARBITER_IFU_raddr` in 32: IFU fetch address.
- `ARBITER_IFU_raddr_ready` out 1: IFU address accepted.
- `ARBITER_IFU_rdata` out 64: returned beat.
- `ARBITER_IFU_rdata_valid` out 1: IFU data valid.
- `ARBITER_IFU_rdata_ready` in 1: IFU can take data.
- `ARBITER_MEM_raddr_valid` in 1: MEM read request valid.
- `ARBITER_MEM_raddr` in 32: MEM read address.
- `ARBITER_MEM_rsize` in 3: AXI size code (0 = byte, 1 = half, 2 = word).
- `ARBITER_MEM_raddr_ready` out 1: MEM address accepted.
- `ARBITER_MEM_rdata` out 64: returned beat.
- `ARBITER_MEM_rdata_valid` out 1: MEM data valid.
- `ARBITER_MEM_rdata_ready` in 1: MEM can take data.
- `io_master_arready` in 1; `io_master_arvalid` out 1; `io_master_araddr` out 32; `io_master_arid` out 4; `io_master_arlen` out 8; `io_master_arsize` out 3; `io_master_arburst` out 2.
- `io_master_rready` out 1; `io_master_rvalid` in 1; `io_master_rresp` in 2; `io_master_rdata` in 64; `io_master_rlast` in 1; `io_master_rid` in 4.
- `ARBITER_error_signal` out 1: registered; set on a bad read response.

## Operation
States: IDLE, AR, R. The registered owner bit `gnt_mem` selects the master.

IDLE:
- If `ARBITER_MEM_raddr_valid`, assert `ARBITER_MEM_raddr_ready` combinationally.
- Otherwise, if `ARBITER_IFU_raddr_valid`, assert `ARBITER_IFU_raddr_ready`.
- MEM has fixed priority, so a load stalled behind a fetch cannot deadlock the pipeline.
- On the handshake, latch the address, size (IFU size forced to 3'b010), ID and `gnt_mem`, then go to AR.

AR:
- `io_master_arvalid` = 1, driven from the latched registers, stable until `arready`.
- On `arvalid & arready`, go to R.
- Fixed outputs: `arlen` = 0, `arburst` = 2'b01 (INCR).

R:
- `io_master_rready` = the owner's `rdata_ready`.
- The owner's `rdata_valid` = `io_master_rvalid`; the non-owner's `rdata_valid` = 0.
- Both `rdata` outputs carry `io_master_rdata` unmodified.
- On `rvalid & rready`, go to IDLE.

Other rules:
- Both `raddr_ready` outputs are 0 outside IDLE.
- `arvalid` is 0 outside AR.
- `rready` is 0 outside R; `rvalid` arriving outside R is ignored.
- Error: on an R-state data handshake, `ARBITER_error_signal` <= (`rresp` != OKAY) | (`rid` != latched ID) | ~`rlast`. The value holds until the next data handshake.

## Timing
Reset (while `rst`=0, asynchronously):
- State = IDLE, `gnt_mem` = 0, latched address/size/ID = 0, `ARBITER_error_signal` = 0.
- All ready/valid outputs = 0, except `raddr_ready`, which follows the IDLE rule once `rst`=1.

Reset mid-transaction:
- Abandon the transaction and return to IDLE.
- The bus is assumed reset together with the arbiter; no drain is performed.

Latency:
- Request handshake in cycle N; `arvalid` high from N+1.
- With `arready` = 1 at N+1, R is entered at N+2.
- Data is forwarded combinationally in the same cycle as `rvalid`.
- Earliest next grant: the cycle after the data handshake.

Back-to-back rule:
- No new grant in the same cycle as the data handshake; IDLE always lasts at least one cycle.

Simultaneous requests:
- MEM is granted.
- IFU keeps `raddr_valid` high and is granted in the next IDLE unless MEM requests again.
- IFU starvation under continuous MEM loads is accepted, because MEM requests are pipeline-bounded.

Master stall:
- If the owner holds `rdata_ready` = 0, `rready` stays 0 and the bus holds `rvalid`/`rdata`.

## Test plan
1. IFU alone, `raddr` = 0x8000_0004, `arready`/`rvalid` = 1 immediately, `rdata` = 0x1122_3344_5566_7788, `rid` = 0, `rlast` = 1 -> `araddr` = 0x8000_0004, `arsize` = 2, `arid` = 0, `arlen` = 0 at cycle 1; IFU `rdata_valid` = 1 with the exact beat at cycle 2; MEM `rdata_valid` = 0; error = 0.
2. IFU and MEM request in the same cycle (MEM 0x8000_1001, `rsize` = 0) -> MEM granted first with `arid` = 1, `arsize` = 0; IFU `raddr_ready` = 0 until MEM data completes; IFU then issued with `arid` = 0.
3. `arready` held low for 5 cycles -> `arvalid` stays 1 and `araddr`/`arsize`/`arid` stay constant across all 5; one AR handshake total.
4. MEM `rdata_ready` = 0 for 3 cycles while `rvalid` = 1 -> `rready` = 0 during those cycles; single handshake when ready rises; state returns to IDLE.
5. `rresp` = 2'b10 (SLVERR) on a MEM read -> `ARBITER_error_signal` = 1 the cycle after the handshake. A following OKAY read with matching `rid` and `rlast` = 1 -> error = 0.
6. Assert `rst` = 0 asynchronously while in AR -> `arvalid` = 0 immediately; after release, a new IFU request is granted from IDLE normally.
